// File: rtl/pkt_buf_ctrl_if.sv
// Ingress, RAM-address and egress signals of the packet buffer controller.
interface pkt_buf_ctrl_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int PCK_LEN    = 12,
  parameter int DESC_DEPTH = 16
);
  localparam int CW = $clog2(DESC_DEPTH) + 1;

  logic                  in_valid;
  logic                  in_sop;
  logic                  in_eop;
  logic                  in_ready;
  logic                  deq_en;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_addr_wr;
  logic                  ram_rd_en;
  logic [ADDR_WIDTH-1:0] ram_addr_rd;
  logic                  out_valid;
  logic                  out_sop;
  logic                  out_eop;
  logic [PCK_LEN-1:0]    out_len;
  logic                  pkt_err;
  logic [CW-1:0]         desc_count;
  logic [ADDR_WIDTH:0]   buf_used;

  modport slave (
    input  in_valid, in_sop, in_eop, deq_en,
    output in_ready, ram_wr_en, ram_addr_wr,
    output ram_rd_en, ram_addr_rd,
    output out_valid, out_sop, out_eop, out_len,
    output pkt_err, desc_count, buf_used
  );

  modport master (
    output in_valid, in_sop, in_eop, deq_en,
    input  in_ready, ram_wr_en, ram_addr_wr,
    input  ram_rd_en, ram_addr_rd,
    input  out_valid, out_sop, out_eop, out_len,
    input  pkt_err, desc_count, buf_used
  );
endinterface

// File: rtl/pkt_buf_ctrl.sv
// Circular packet buffer sequencer: write addressing, descriptor FIFO,
// and a whole-packet read scheduler aligned to the RAM's registered output.
module pkt_buf_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int PCK_LEN    = 12,
  parameter int DESC_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  pkt_buf_ctrl_if.slave bus
);
  localparam int BW = ADDR_WIDTH + 1;
  localparam int CW = $clog2(DESC_DEPTH) + 1;
  localparam int IW = $clog2(DESC_DEPTH);
  localparam logic [PCK_LEN-1:0] LMAX = '1;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] start;
    logic [PCK_LEN-1:0]    len;
  } desc_t;

  typedef enum logic {IDLE, READ} state_t;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] pkt_start_q, pkt_start_d;
  logic [PCK_LEN-1:0]    wcnt_q, wcnt_d;
  logic                  open_q, open_d;
  logic [BW-1:0]         buf_used_q, buf_used_d;
  logic [CW-1:0]         desc_cnt_q, desc_cnt_d;
  logic [IW-1:0]         dwr_q, dwr_d;
  logic [IW-1:0]         drd_q, drd_d;
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PCK_LEN-1:0]    len_q, len_d;
  logic [PCK_LEN-1:0]    rcnt_q, rcnt_d;
  logic                  ov_q, ov_d;
  logic                  osop_q, osop_d;
  logic                  oeop_q, oeop_d;
  logic [PCK_LEN-1:0]    olen_q, olen_d;
  logic                  err_q, err_d;

  desc_t                 fifo_q [DESC_DEPTH];
  desc_t                 push_desc;
  desc_t                 head;
  desc_t                 nxt;

  logic                  in_ready;
  logic                  acc;
  logic                  wr_en;
  logic                  push;
  logic                  drop;
  logic [ADDR_WIDTH-1:0] base;
  logic                  rd_en;
  logic                  pop;
  logic                  last;

  // Counters never exceed capacity, so the MSB alone flags "full".
  assign in_ready = !buf_used_q[ADDR_WIDTH] && !desc_cnt_q[CW-1];
  assign acc      = bus.in_valid && in_ready;

  always_comb begin
    wr_en       = 1'b0;
    push        = 1'b0;
    drop        = 1'b0;
    base        = wr_ptr_q;
    push_desc   = '0;
    wr_ptr_d    = wr_ptr_q;
    pkt_start_d = pkt_start_q;
    wcnt_d      = wcnt_q;
    open_d      = open_q;
    if (acc && bus.in_sop) begin
      // A sop inside an open packet discards it and reuses its start.
      drop        = open_q;
      base        = open_q ? pkt_start_q : wr_ptr_q;
      wr_en       = 1'b1;
      pkt_start_d = base;
      wr_ptr_d    = base + 1'b1;
      wcnt_d      = PCK_LEN'(1);
      open_d      = !bus.in_eop;
      push        = bus.in_eop;
      push_desc   = {base, PCK_LEN'(1)};
    end else if (acc && open_q) begin
      if (wcnt_q == LMAX) begin
        drop     = 1'b1;
        wr_ptr_d = pkt_start_q;
        wcnt_d   = '0;
        open_d   = 1'b0;
      end else begin
        wr_en     = 1'b1;
        wr_ptr_d  = wr_ptr_q + 1'b1;
        wcnt_d    = wcnt_q + PCK_LEN'(1);
        open_d    = !bus.in_eop;
        push      = bus.in_eop;
        push_desc = {pkt_start_q, wcnt_q + PCK_LEN'(1)};
      end
    end
  end

  assign head = fifo_q[drd_q];
  assign nxt  = fifo_q[drd_q + IW'(1)];

  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    rcnt_d   = rcnt_q;
    rd_en    = 1'b0;
    pop      = 1'b0;
    last     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (desc_cnt_q != '0 && bus.deq_en) begin
          state_d  = READ;
          rd_ptr_d = head.start;
          len_d    = head.len;
          rcnt_d   = '0;
        end
      end
      READ: begin
        rd_en    = 1'b1;
        rd_ptr_d = rd_ptr_q + 1'b1;
        rcnt_d   = rcnt_q + PCK_LEN'(1);
        last     = rcnt_q == len_q - PCK_LEN'(1);
        if (last) begin
          pop = 1'b1;
          // Chain straight into the next packet to avoid a bubble.
          if (desc_cnt_q > CW'(1) && bus.deq_en) begin
            rd_ptr_d = nxt.start;
            len_d    = nxt.len;
            rcnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_used_d = buf_used_q + BW'(wr_en);
    if (drop) buf_used_d = buf_used_d - BW'(wcnt_q);
    if (pop)  buf_used_d = buf_used_d - BW'(len_q);
    desc_cnt_d = desc_cnt_q + CW'(push) - CW'(pop);
    dwr_d      = push ? dwr_q + IW'(1) : dwr_q;
    drd_d      = pop  ? drd_q + IW'(1) : drd_q;
    ov_d       = rd_en;
    osop_d     = rd_en && rcnt_q == '0;
    oeop_d     = last;
    olen_d     = rd_en ? len_q : '0;
    err_d      = drop;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[dwr_q] <= push_desc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      pkt_start_q <= '0;
      wcnt_q      <= '0;
      open_q      <= 1'b0;
      buf_used_q  <= '0;
      desc_cnt_q  <= '0;
      dwr_q       <= '0;
      drd_q       <= '0;
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      rcnt_q      <= '0;
      ov_q        <= 1'b0;
      osop_q      <= 1'b0;
      oeop_q      <= 1'b0;
      olen_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      pkt_start_q <= pkt_start_d;
      wcnt_q      <= wcnt_d;
      open_q      <= open_d;
      buf_used_q  <= buf_used_d;
      desc_cnt_q  <= desc_cnt_d;
      dwr_q       <= dwr_d;
      drd_q       <= drd_d;
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      rcnt_q      <= rcnt_d;
      ov_q        <= ov_d;
      osop_q      <= osop_d;
      oeop_q      <= oeop_d;
      olen_q      <= olen_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.ram_wr_en   = wr_en;
  assign bus.ram_addr_wr = base;
  assign bus.ram_rd_en   = rd_en;
  assign bus.ram_addr_rd = rd_ptr_q;
  assign bus.out_valid   = ov_q;
  assign bus.out_sop     = osop_q;
  assign bus.out_eop     = oeop_q;
  assign bus.out_len     = olen_q;
  assign bus.pkt_err     = err_q;
  assign bus.desc_count  = desc_cnt_q;
  assign bus.buf_used    = buf_used_q;
endmodule

// File: tb/tb_pkt_buf_ctrl.sv
// Bench for pkt_buf_ctrl: shadow RAM tags each written word, egress is
// compared word-by-word with the packets the bench committed.
module tb_pkt_buf_ctrl;
  localparam int AW = 4;
  localparam int PL = 4;
  localparam int DD = 4;

  typedef struct {
    int tag;
    bit sop;
    bit eop;
    int len;
  } ew_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   cur_tag;

  int   cyc;
  int   err_cnt;
  int   pend_tag;
  int   shadow [16];
  int   wr_log[$];
  int   wr_cyc[$];
  int   rd_log[$];
  int   rd_cyc[$];
  ew_t  got_q[$];

  pkt_buf_ctrl_if #(
    .ADDR_WIDTH(AW), .PCK_LEN(PL), .DESC_DEPTH(DD)
  ) bus ();

  pkt_buf_ctrl #(
    .ADDR_WIDTH(AW), .PCK_LEN(PL), .DESC_DEPTH(DD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observer: shadow RAM plus logs; data from a read shows up a cycle later.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      err_cnt = 0;
      wr_log.delete();
      wr_cyc.delete();
      rd_log.delete();
      rd_cyc.delete();
      got_q.delete();
    end else begin
      if (bus.out_valid)
        got_q.push_back('{pend_tag, bus.out_sop,
                          bus.out_eop, int'(bus.out_len)});
      if (bus.ram_wr_en) begin
        shadow[bus.ram_addr_wr] = cur_tag;
        wr_log.push_back(int'(bus.ram_addr_wr));
        wr_cyc.push_back(cyc);
      end
      if (bus.ram_rd_en) begin
        pend_tag = shadow[bus.ram_addr_rd];
        rd_log.push_back(int'(bus.ram_addr_rd));
        rd_cyc.push_back(cyc);
      end
      if (bus.pkt_err) err_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
    bus.deq_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
  endtask

  task automatic beat(input bit s, input bit e, input int tag);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_sop = s;
    bus.in_eop = e;
    cur_tag = tag;
    #1;
    while (!bus.in_ready && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (n >= 300) begin
      bad++;
      $display("FAIL beat_timeout tag=%0d in_ready=%0b want 1",
               tag, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((bus.buf_used != 0 || bus.desc_count != 0 ||
            bus.ram_rd_en || bus.out_valid) && n < 400) begin
      tick();
      n++;
    end
    repeat (3) tick();
    total++;
    if (n >= 400) begin
      bad++;
      $display("FAIL drain_timeout buf_used=%0d desc=%0d want 0/0",
               bus.buf_used, bus.desc_count);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
    bus.deq_en = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.out_sop, bus.out_eop, bus.pkt_err,
         bus.ram_rd_en, bus.ram_wr_en} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want 000000",
               {bus.out_valid, bus.out_sop, bus.out_eop, bus.pkt_err,
                bus.ram_rd_en, bus.ram_wr_en});
    end
    total++;
    if (bus.out_len !== '0 || bus.desc_count !== '0 ||
        bus.buf_used !== '0) begin
      bad++;
      $display("FAIL reset_counts len=%0d desc=%0d used=%0d want 0",
               bus.out_len, bus.desc_count, bus.buf_used);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    total++;
    if (bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_three_word();
    do_reset();
    bus.deq_en = 1'b1;
    beat(1, 0, 1);
    beat(0, 0, 2);
    beat(0, 1, 3);
    total++;
    if (bus.buf_used !== 5'd3 || bus.desc_count !== 3'd1) begin
      bad++;
      $display("FAIL three_post_eop used=%0d desc=%0d want 3/1",
               bus.buf_used, bus.desc_count);
    end
    drain();
    total++;
    if (wr_log.size() != 3 || rd_log.size() != 3 ||
        got_q.size() != 3) begin
      bad++;
      $display("FAIL three_sizes wr=%0d rd=%0d out=%0d want 3",
               wr_log.size(), rd_log.size(), got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wr_log[i] != i || rd_log[i] != i ||
            rd_cyc[i] != wr_cyc[2] + 2 + i) begin
          bad++;
          $display("FAIL three_addr i=%0d wr=%0d rd=%0d dly=%0d want %0d/2",
                   i, wr_log[i], rd_log[i], rd_cyc[i] - wr_cyc[2] - i, i);
        end
        total++;
        if (got_q[i].tag != i + 1 || got_q[i].sop != (i == 0) ||
            got_q[i].eop != (i == 2) || got_q[i].len != 3) begin
          bad++;
          $display("FAIL three_out i=%0d tag=%0d s=%0b e=%0b len=%0d",
                   i, got_q[i].tag, got_q[i].sop, got_q[i].eop,
                   got_q[i].len);
        end
      end
    end
  endtask

  task automatic test_one_word();
    do_reset();
    bus.deq_en = 1'b1;
    beat(1, 1, 7);
    total++;
    if (bus.desc_count !== 3'd1) begin
      bad++;
      $display("FAIL one_desc got=%0d want 1", bus.desc_count);
    end
    drain();
    total++;
    if (got_q.size() != 1 || rd_log.size() != 1) begin
      bad++;
      $display("FAIL one_size out=%0d rd=%0d want 1",
               got_q.size(), rd_log.size());
    end else if (got_q[0].tag != 7 || !got_q[0].sop ||
                 !got_q[0].eop || got_q[0].len != 1) begin
      bad++;
      $display("FAIL one_out tag=%0d s=%0b e=%0b len=%0d want 7/1/1/1",
               got_q[0].tag, got_q[0].sop, got_q[0].eop, got_q[0].len);
    end
  endtask

  task automatic test_back_to_back();
    int tags [6] = '{10, 11, 20, 21, 22, 23};
    do_reset();
    beat(1, 0, 10);
    beat(0, 1, 11);
    beat(1, 0, 20);
    beat(0, 0, 21);
    beat(0, 0, 22);
    beat(0, 1, 23);
    repeat (2) tick();
    total++;
    if (bus.desc_count !== 3'd2 || rd_log.size() != 0) begin
      bad++;
      $display("FAIL b2b_hold desc=%0d reads=%0d want 2/0",
               bus.desc_count, rd_log.size());
    end
    bus.deq_en = 1'b1;
    drain();
    total++;
    if (rd_log.size() != 6 || got_q.size() != 6) begin
      bad++;
      $display("FAIL b2b_size rd=%0d out=%0d want 6",
               rd_log.size(), got_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        total++;
        if (rd_log[i] != i || rd_cyc[i] != rd_cyc[0] + i ||
            got_q[i].tag != tags[i] ||
            got_q[i].sop != (i == 0 || i == 2) ||
            got_q[i].eop != (i == 1 || i == 5) ||
            got_q[i].len != (i < 2 ? 2 : 4)) begin
          bad++;
          $display("FAIL b2b_word i=%0d addr=%0d gap=%0d tag=%0d e=%0b",
                   i, rd_log[i], rd_cyc[i] - rd_cyc[0] - i,
                   got_q[i].tag, got_q[i].eop);
        end
      end
    end
  endtask

  task automatic test_full();
    int n;
    do_reset();
    for (int i = 0; i < 10; i++) beat(i == 0, i == 9, 100 + i);
    for (int i = 0; i < 6; i++) beat(i == 0, i == 5, 200 + i);
    total++;
    if (bus.in_ready !== 1'b0 || bus.buf_used !== 5'd16 ||
        bus.desc_count !== 3'd2) begin
      bad++;
      $display("FAIL full_stop rdy=%b used=%0d desc=%0d want 0/16/2",
               bus.in_ready, bus.buf_used, bus.desc_count);
    end
    bus.deq_en = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (n >= 100 || bus.buf_used !== 5'd6 || rd_log.size() != 10) begin
      bad++;
      $display("FAIL full_release used=%0d reads=%0d want 6/10",
               bus.buf_used, rd_log.size());
    end
    drain();
    total++;
    if (got_q.size() != 16) begin
      bad++;
      $display("FAIL full_out got=%0d want 16", got_q.size());
    end
  endtask

  task automatic test_wrap();
    int wb;
    int rb;
    int ob;
    int ea [4] = '{14, 15, 0, 1};
    do_reset();
    bus.deq_en = 1'b1;
    for (int i = 0; i < 14; i++) beat(i == 0, i == 13, 300 + i);
    drain();
    wb = wr_log.size();
    rb = rd_log.size();
    ob = got_q.size();
    for (int i = 0; i < 4; i++) beat(i == 0, i == 3, 400 + i);
    drain();
    total++;
    if (wr_log.size() != wb + 4 || rd_log.size() != rb + 4 ||
        got_q.size() != ob + 4) begin
      bad++;
      $display("FAIL wrap_size wr=%0d rd=%0d out=%0d want 4 each",
               wr_log.size() - wb, rd_log.size() - rb, got_q.size() - ob);
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (wr_log[wb+i] != ea[i] || rd_log[rb+i] != ea[i] ||
            got_q[ob+i].tag != 400 + i ||
            got_q[ob+i].sop != (i == 0) ||
            got_q[ob+i].eop != (i == 3)) begin
          bad++;
          $display("FAIL wrap_word i=%0d wr=%0d rd=%0d tag=%0d want %0d",
                   i, wr_log[wb+i], rd_log[rb+i], got_q[ob+i].tag, ea[i]);
        end
      end
    end
  endtask

  task automatic test_sop_abort();
    int ea [5] = '{0, 1, 0, 1, 2};
    do_reset();
    beat(1, 0, 1);
    beat(0, 0, 2);
    beat(1, 0, 3);
    beat(0, 0, 4);
    beat(0, 1, 5);
    repeat (2) tick();
    total++;
    if (err_cnt != 1 || bus.desc_count !== 3'd1 ||
        bus.buf_used !== 5'd3) begin
      bad++;
      $display("FAIL abort_state err=%0d desc=%0d used=%0d want 1/1/3",
               err_cnt, bus.desc_count, bus.buf_used);
    end
    total++;
    if (wr_log.size() != 5) begin
      bad++;
      $display("FAIL abort_wr got=%0d writes want 5", wr_log.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        total++;
        if (wr_log[i] != ea[i]) begin
          bad++;
          $display("FAIL abort_addr i=%0d got=%0d want %0d",
                   i, wr_log[i], ea[i]);
        end
      end
    end
    bus.deq_en = 1'b1;
    drain();
    total++;
    if (got_q.size() != 3) begin
      bad++;
      $display("FAIL abort_out got=%0d words want 3", got_q.size());
    end else if (got_q[0].tag != 3 || got_q[2].tag != 5 ||
                 !got_q[0].sop || !got_q[2].eop || got_q[1].len != 3) begin
      bad++;
      $display("FAIL abort_pkt tags=%0d..%0d len=%0d want 3..5 len 3",
               got_q[0].tag, got_q[2].tag, got_q[1].len);
    end
  endtask

  task automatic test_len_overflow();
    do_reset();
    for (int i = 0; i < 15; i++) beat(i == 0, 0, 50 + i);
    total++;
    if (bus.buf_used !== 5'd15 || err_cnt != 0) begin
      bad++;
      $display("FAIL ovf_pre used=%0d err=%0d want 15/0",
               bus.buf_used, err_cnt);
    end
    beat(0, 0, 65);
    beat(0, 1, 66);
    tick();
    total++;
    if (err_cnt != 1 || bus.buf_used !== '0 ||
        bus.desc_count !== '0 || wr_log.size() != 15) begin
      bad++;
      $display("FAIL ovf_drop err=%0d used=%0d desc=%0d wr=%0d",
               err_cnt, bus.buf_used, bus.desc_count, wr_log.size());
    end
    beat(1, 0, 70);
    beat(0, 1, 71);
    bus.deq_en = 1'b1;
    drain();
    total++;
    if (wr_log.size() != 17 || got_q.size() != 2) begin
      bad++;
      $display("FAIL ovf_next wr=%0d out=%0d want 17/2",
               wr_log.size(), got_q.size());
    end else if (wr_log[15] != 0 || got_q[0].tag != 70 ||
                 got_q[1].tag != 71) begin
      bad++;
      $display("FAIL ovf_rewind addr=%0d tags=%0d,%0d want 0/70,71",
               wr_log[15], got_q[0].tag, got_q[1].tag);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    do_reset();
    bus.deq_en = 1'b1;
    for (int i = 0; i < 8; i++) beat(i == 0, i == 7, 500 + i);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (n >= 20) begin
      bad++;
      $display("FAIL midrd_wait out_valid=%b want 1", bus.out_valid);
    end
    rst = 1'b0;
    bus.deq_en = 1'b0;
    #1;
    total++;
    if ({bus.out_valid, bus.out_sop, bus.out_eop, bus.ram_rd_en,
         bus.pkt_err} !== 5'b0 || bus.out_len !== '0 ||
        bus.desc_count !== '0 || bus.buf_used !== '0) begin
      bad++;
      $display("FAIL midrd_reset v=%b rd=%b desc=%0d used=%0d want 0",
               bus.out_valid, bus.ram_rd_en, bus.desc_count, bus.buf_used);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_random();
    ew_t exp_q[$];
    int  aborts;
    int  tag;
    int  len;
    int  nsend;
    bit  ab;
    aborts = 0;
    tag = 1000;
    do_reset();
    for (int p = 0; p < 40; p++) begin
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 15)
                                        : $urandom_range(1, 7);
      ab = (p != 39) && (len >= 2) && ($urandom_range(0, 6) == 0);
      nsend = ab ? $urandom_range(1, len - 1) : len;
      for (int w = 0; w < nsend; w++) begin
        if ($urandom_range(0, 3) == 0) tick();
        bus.deq_en = !bus.in_ready ? 1'b1 : ($urandom_range(0, 2) != 0);
        beat(w == 0, !ab && w == len - 1, tag + w);
        if (!ab) exp_q.push_back('{tag + w, w == 0, w == len - 1, len});
      end
      if (ab) aborts++;
      tag += 100;
    end
    bus.deq_en = 1'b1;
    drain();
    total++;
    if (err_cnt != aborts) begin
      bad++;
      $display("FAIL rand_err got=%0d want %0d", err_cnt, aborts);
    end
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL rand_count got=%0d want %0d",
               got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        total++;
        if (got_q[i] != exp_q[i]) begin
          bad++;
          $display("FAIL rand_word i=%0d got=%0d/%0b/%0b/%0d want %0d/%0b/%0b/%0d",
                   i, got_q[i].tag, got_q[i].sop, got_q[i].eop,
                   got_q[i].len, exp_q[i].tag, exp_q[i].sop,
                   exp_q[i].eop, exp_q[i].len);
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    cur_tag = 0;
    test_reset();
    test_three_word();
    test_one_word();
    test_back_to_back();
    test_full();
    test_wrap();
    test_sop_abort();
    test_len_overflow();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
